// File: rtl/key_repeat_pkg.sv
// Shared types and default timing for the per-key auto-repeat (DAS) stage.
package key_repeat_pkg;

  typedef enum logic [1:0] {
    KR_IDLE   = 2'd0,
    KR_DELAY  = 2'd1,
    KR_REPEAT = 2'd2
  } kr_state_e;

  localparam int unsigned KR_DAS_DELAY_CYCLES = 2500000;
  localparam int unsigned KR_RATE_CYCLES      = 625000;
  localparam int unsigned KR_ACCEL_AFTER      = 4;

endpackage

// File: rtl/key_repeat.sv
// Turns debounced press/release pulses into move strobes with delayed auto-repeat.
// Optional repeat acceleration is enabled with `define KEY_REPEAT_ACCEL_EN.
module key_repeat
  import key_repeat_pkg::*;
#(
  parameter int unsigned DELAY_CYCLES = KR_DAS_DELAY_CYCLES,
  parameter int unsigned RATE_CYCLES  = KR_RATE_CYCLES,
  parameter int unsigned CNT_W        = 24,
  parameter int unsigned ACCEL_AFTER  = KR_ACCEL_AFTER
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic press_pulse,
  input  logic release_pulse,
  output logic move,
  output logic held
);

  localparam logic [CNT_W-1:0] DELAY_TC = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] RATE_TC  = CNT_W'(RATE_CYCLES - 1);

`ifdef KEY_REPEAT_ACCEL_EN
  localparam int unsigned      FAST_CYCLES = ((RATE_CYCLES >> 1) < 2) ? 2 : (RATE_CYCLES >> 1);
  localparam logic [CNT_W-1:0] FAST_TC     = CNT_W'(FAST_CYCLES - 1);

  logic [3:0] rep_cnt_q, rep_cnt_d;
`endif

  kr_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             move_q, move_d;
  logic             held_q, held_d;
  logic [CNT_W-1:0] period_tc;

  always_comb begin
    period_tc = RATE_TC;
`ifdef KEY_REPEAT_ACCEL_EN
    if ({28'd0, rep_cnt_q} >= ACCEL_AFTER) period_tc = FAST_TC;
`endif

    state_d = state_q;
    cnt_d   = cnt_q;
    move_d  = 1'b0;

    if (!en) begin
      state_d = KR_IDLE;
      cnt_d   = '0;
    end else if (release_pulse) begin
      state_d = KR_IDLE;
      cnt_d   = '0;
    end else if (press_pulse) begin
      state_d = KR_DELAY;
      cnt_d   = '0;
      move_d  = 1'b1;
    end else begin
      case (state_q)
        KR_DELAY: begin
          if (cnt_q == DELAY_TC) begin
            state_d = KR_REPEAT;
            cnt_d   = '0;
            move_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        KR_REPEAT: begin
          if (cnt_q == period_tc) begin
            cnt_d  = '0;
            move_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = KR_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Back-to-back strobes are only reachable by a press right after a terminal
    // count; the restart still happens, only the second strobe is dropped.
    move_d = move_d & ~move_q;
    held_d = (state_d != KR_IDLE);

`ifdef KEY_REPEAT_ACCEL_EN
    rep_cnt_d = rep_cnt_q;
    if (state_d != KR_REPEAT)
      rep_cnt_d = '0;
    else if (move_d && (rep_cnt_q != 4'hF))
      rep_cnt_d = rep_cnt_q + 4'd1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= KR_IDLE;
      cnt_q     <= '0;
      move_q    <= 1'b0;
      held_q    <= 1'b0;
`ifdef KEY_REPEAT_ACCEL_EN
      rep_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      move_q    <= move_d;
      held_q    <= held_d;
`ifdef KEY_REPEAT_ACCEL_EN
      rep_cnt_q <= rep_cnt_d;
`endif
    end
  end

  assign move = move_q;
  assign held = held_q;

endmodule
